psu_uc_sequencer: RTL and testbench
===================================

Name: psu_uc_sequencer

Overview:
- Producer side of the PSU opcode/location path: accepts one logical-operation command and drives `opcode_running`, `pchop_list` and per-UCC `uc_counter` into the combinational opcode/location decoder.
- Walks every unit cell of the patch, split evenly across NUM_UCC controllers, for a programmable number of rounds.
- Paces stepping on a UCC-side ready signal and pulses done at completion.

Parameters:
- OPCODE_BW, 4, opcode width.
- UCADDR_BW, 8, unit-cell index width per UCC.
- NUM_UCC, 4, number of unit-cell controllers.
- NUM_PCU, 4, number of patch control units.
- NUM_UCROW, 8, unit-cell rows.
- NUM_UCCOL, 8, unit-cell columns.
- ROUND_BW, 4, round-count width.
- NOP_OPCODE, 0, opcode driven while idle.
- Derived: NUM_CELLS = NUM_UCROW*NUM_UCCOL; STEPS = NUM_CELLS/NUM_UCC.
- Legal configurations: NUM_CELLS divisible by NUM_UCC, and NUM_CELLS-1 < 2^UCADDR_BW. Elaboration error otherwise.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_opcode  in  OPCODE_BW  operation opcode.
- cmd_pchop  in  NUM_PCU*2*OPCODE_BW  per-PCU opcode pairs, used for LQM ops.
- cmd_rounds  in  ROUND_BW  round count; 0 is treated as 1.
- abort  in  1  synchronous cancel.
- ucc_ready  in  1  all UCCs have consumed the current step.
- opcode_running  out  OPCODE_BW  active opcode.
- pchop_list  out  NUM_PCU*2*OPCODE_BW  latched opcode pairs.
- uc_counter  out  NUM_UCC*UCADDR_BW  per-UCC unit-cell index.
- uc_valid  out  1  uc_counter/opcode are valid this cycle.
- busy  out  1  not idle.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0), all outputs take these values:
  - state IDLE;
  - cmd_ready=1, uc_valid=0, busy=0, done=0;
  - opcode_running=NOP_OPCODE;
  - pchop_list=0, uc_counter=0;
  - step and round counters 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch cmd_opcode→opcode_running, cmd_pchop→pchop_list, rounds_tgt=max(cmd_rounds,1).
  - Clear step and round counters; go to RUN.
  - uc_valid rises on the cycle after the accept (1-cycle latency).
- RUN:
  - uc_valid=1, busy=1, cmd_ready=0.
  - UCC j output: uc_counter[j]=j*STEPS+step.
  - Step advances only when ucc_ready=1. ucc_ready=0 holds every output unchanged, with no cap on stall length.
  - Step wrap: step==STEPS-1 with ucc_ready → step=0 and round+1.
  - Last step of last round (round==rounds_tgt-1) with ucc_ready → go to DONE.
- DONE:
  - done=1 for exactly one cycle; uc_valid=0, busy=1.
  - Next cycle IDLE, opcode_running=NOP_OPCODE, uc_counter=0.
  - pchop_list holds its last value until the next accept.
- Abort:
  - abort=1 in RUN or DONE → IDLE next cycle; done is not pulsed.
  - abort has priority over a simultaneous ucc_ready.
  - abort in IDLE is ignored; abort together with cmd_valid in IDLE → the command is accepted.
- Backpressure: a command offered while busy is not accepted (cmd_ready=0). The command source holds cmd_* stable until accepted.
- Reset mid-operation: immediate return to reset values; no done.
- Arithmetic: j*STEPS+step computed at UCADDR_BW width, cannot overflow under the legal configurations above. The step counter is sized to cover STEPS-1.
- pchop_list and opcode_running are stable for the whole of RUN. The downstream decoder derives LQM per-PCU opcodes from pchop_list.

Test Plan:
- Basic walk, defaults, rounds=1:
  - Stimulus: accept opcode 5, ucc_ready tied 1.
  - Response: uc_valid for 16 cycles; uc_counter[0] goes 0..15, [1] 16..31, [3] 48..63; done pulses the cycle after the last step; cmd_ready returns 1 the following cycle.
- Multi-round:
  - Stimulus: cmd_rounds=3.
  - Response: 48 valid cycles, step wraps 15→0 twice, exactly one done.
  - Stimulus: cmd_rounds=0.
  - Response: behaves as 1 round (16 valid cycles).
- Stall:
  - Stimulus: ucc_ready=0 for 5 cycles at step 7.
  - Response: uc_counter[2]=39 held for 6 cycles; total RUN length 21 cycles.
- Abort:
  - Stimulus: abort at step 10 together with ucc_ready=1.
  - Response: IDLE next cycle, no done, opcode_running=NOP_OPCODE, uc_counter=0.
- Command while busy:
  - Stimulus: cmd_valid held with a new opcode during RUN.
  - Response: not accepted until IDLE; second op starts the cycle after cmd_ready rises; pchop_list is updated only at that accept.
- Async reset:
  - Stimulus: rst_n low mid-RUN, between clock edges.
  - Response: outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/psu_uc_sequencer_if.sv
// Command/step bus between a command source and the PSU unit-cell sequencer.
// The master issues commands and UCC readiness; the slave drives the decoder-facing outputs.
interface psu_uc_sequencer_if #(
  parameter int OPCODE_BW = 4,
  parameter int UCADDR_BW = 8,
  parameter int NUM_UCC   = 4,
  parameter int NUM_PCU   = 4,
  parameter int ROUND_BW  = 4
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [OPCODE_BW-1:0]            cmd_opcode;
  logic [NUM_PCU*2*OPCODE_BW-1:0]  cmd_pchop;
  logic [ROUND_BW-1:0]             cmd_rounds;
  logic                            abort;
  logic                            ucc_ready;
  logic [OPCODE_BW-1:0]            opcode_running;
  logic [NUM_PCU*2*OPCODE_BW-1:0]  pchop_list;
  logic [NUM_UCC*UCADDR_BW-1:0]    uc_counter;
  logic                            uc_valid;
  logic                            busy;
  logic                            done;

  modport master (
    output cmd_valid, cmd_opcode, cmd_pchop, cmd_rounds, abort, ucc_ready,
    input  cmd_ready, opcode_running, pchop_list, uc_counter, uc_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_pchop, cmd_rounds, abort, ucc_ready,
    output cmd_ready, opcode_running, pchop_list, uc_counter, uc_valid, busy, done
  );
endinterface

// File: rtl/psu_uc_sequencer.sv
// PSU unit-cell sequencer: latches one command and walks every unit cell of the patch,
// split evenly over NUM_UCC controllers, for a programmable number of rounds.
module psu_uc_sequencer #(
  parameter int OPCODE_BW  = 4,
  parameter int UCADDR_BW  = 8,
  parameter int NUM_UCC    = 4,
  parameter int NUM_PCU    = 4,
  parameter int NUM_UCROW  = 8,
  parameter int NUM_UCCOL  = 8,
  parameter int ROUND_BW   = 4,
  parameter int NOP_OPCODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  psu_uc_sequencer_if.slave  bus
);
  localparam int NUM_CELLS = NUM_UCROW * NUM_UCCOL;
  localparam int STEPS     = NUM_CELLS / NUM_UCC;
  localparam int STEP_BW   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PCHOP_BW  = NUM_PCU * 2 * OPCODE_BW;
  localparam int UCV_BW    = NUM_UCC * UCADDR_BW;

  if (((NUM_CELLS % NUM_UCC) != 0) || ((NUM_CELLS - 1) >= (2 ** UCADDR_BW))) begin : g_bad_cfg
    $error("psu_uc_sequencer: illegal NUM_UCC/UCADDR_BW for this patch size");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [STEP_BW-1:0]    r_step;
  logic [ROUND_BW-1:0]   r_round;
  logic [ROUND_BW-1:0]   r_rounds_tgt;
  logic                  r_cmd_ready;
  logic                  r_uc_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [OPCODE_BW-1:0]  r_opcode;
  logic [PCHOP_BW-1:0]   r_pchop;
  logic [UCV_BW-1:0]     r_uc_counter;

  logic                  w_go_idle;
  logic                  w_last_step;
  logic                  w_last_round;
  logic [STEP_BW-1:0]    w_step_nxt;
  logic [ROUND_BW-1:0]   w_rounds_cmd;

  // UCC j sees cell j*STEPS+step; the sum fits UCADDR_BW for any legal configuration.
  function automatic logic [UCV_BW-1:0] f_uc_vec(input logic [STEP_BW-1:0] step);
    logic [UCV_BW-1:0] v;
    v = {UCV_BW{1'b0}};
    for (int j = 0; j < NUM_UCC; j++) begin
      v[j*UCADDR_BW +: UCADDR_BW] = UCADDR_BW'(j * STEPS) + UCADDR_BW'(step);
    end
    return v;
  endfunction

  // DONE always falls back to IDLE; abort only matters once a command is in flight.
  assign w_go_idle    = (r_state != S_IDLE) && ((r_state != S_RUN) || bus.abort);
  assign w_last_step  = (r_step == STEP_BW'(STEPS - 1));
  assign w_last_round = (r_round == (r_rounds_tgt - ROUND_BW'(1)));
  assign w_step_nxt   = r_step + STEP_BW'(1);
  assign w_rounds_cmd = (bus.cmd_rounds == {ROUND_BW{1'b0}}) ? ROUND_BW'(1) : bus.cmd_rounds;

  // Sequencer FSM with all decoder-facing outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_step       <= {STEP_BW{1'b0}};
      r_round      <= {ROUND_BW{1'b0}};
      r_rounds_tgt <= {ROUND_BW{1'b0}};
      r_cmd_ready  <= 1'b1;
      r_uc_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_opcode     <= OPCODE_BW'(NOP_OPCODE);
      r_pchop      <= {PCHOP_BW{1'b0}};
      r_uc_counter <= {UCV_BW{1'b0}};
    end else if (w_go_idle) begin
      r_state      <= S_IDLE;
      r_step       <= {STEP_BW{1'b0}};
      r_round      <= {ROUND_BW{1'b0}};
      r_cmd_ready  <= 1'b1;
      r_uc_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_opcode     <= OPCODE_BW'(NOP_OPCODE);
      r_uc_counter <= {UCV_BW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            r_state      <= S_RUN;
            r_step       <= {STEP_BW{1'b0}};
            r_round      <= {ROUND_BW{1'b0}};
            r_rounds_tgt <= w_rounds_cmd;
            r_cmd_ready  <= 1'b0;
            r_uc_valid   <= 1'b1;
            r_busy       <= 1'b1;
            r_opcode     <= bus.cmd_opcode;
            r_pchop      <= bus.cmd_pchop;
            r_uc_counter <= f_uc_vec({STEP_BW{1'b0}});
          end
        end
        S_RUN: begin
          if (bus.ucc_ready) begin
            if (w_last_step && w_last_round) begin
              r_state    <= S_DONE;
              r_uc_valid <= 1'b0;
              r_done     <= 1'b1;
            end else if (w_last_step) begin
              r_step       <= {STEP_BW{1'b0}};
              r_round      <= r_round + ROUND_BW'(1);
              r_uc_counter <= f_uc_vec({STEP_BW{1'b0}});
            end else begin
              r_step       <= w_step_nxt;
              r_uc_counter <= f_uc_vec(w_step_nxt);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.uc_valid       = r_uc_valid;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.opcode_running = r_opcode;
  assign bus.pchop_list     = r_pchop;
  assign bus.uc_counter     = r_uc_counter;
endmodule

// File: tb/tb_psu_uc_sequencer.sv
// Scoreboard bench for psu_uc_sequencer: stimulus queues expected steps and done pulses,
// a negedge monitor pops and compares them whenever the DUT presents a consumed step or done.
module tb_psu_uc_sequencer;
  localparam int OBW   = 4;
  localparam int UBW   = 8;
  localparam int NU    = 4;
  localparam int NP    = 4;
  localparam int RBW   = 4;
  localparam int STEPS = 16;
  localparam int PW    = NP * 2 * OBW;
  localparam int UW    = NU * UBW;

  typedef struct {
    logic [OBW-1:0] op;
    logic [PW-1:0]  pchop;
    logic [UW-1:0]  ucv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psu_uc_sequencer_if #(.OPCODE_BW(OBW), .UCADDR_BW(UBW), .NUM_UCC(NU), .NUM_PCU(NP),
                        .ROUND_BW(RBW)) bus_if ();

  psu_uc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  exp_t           exp_q[$];
  logic [OBW-1:0] done_q[$];
  int errors  = 0;
  int checks  = 0;
  int n_valid = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [UW-1:0] uc_vec(input int s);
    logic [UW-1:0] v;
    v = '0;
    for (int j = 0; j < NU; j++) v[j*UBW +: UBW] = 8'(j * STEPS + s);
    return v;
  endfunction

  task automatic push_walk(input logic [OBW-1:0] op, input logic [PW-1:0] pc, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.op = op; e.pchop = pc; e.ucv = uc_vec(k % STEPS);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a step counts as presented when uc_valid and ucc_ready meet.
  always @(negedge clk) begin
    exp_t e;
    logic [OBW-1:0] dop;
    if (rst_n) begin
      if (bus_if.uc_valid) begin
        n_valid++;
        if (bus_if.ucc_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_step", {32'd0, bus_if.uc_counter}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("mon_opcode", 64'(bus_if.opcode_running), 64'(e.op));
            chk("mon_pchop", 64'(bus_if.pchop_list), 64'(e.pchop));
            chk("mon_uc_counter", 64'(bus_if.uc_counter), 64'(e.ucv));
          end
        end
      end
      if (bus_if.done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          dop = done_q.pop_front();
          chk("mon_done_opcode", 64'(bus_if.opcode_running), 64'(dop));
          chk("mon_done_uc_valid", 64'(bus_if.uc_valid), 64'd0);
        end
      end
    end
  end

  task automatic drive_cmd(input logic [OBW-1:0] op, input logic [PW-1:0] pc, input logic [RBW-1:0] r);
    bus_if.cmd_valid  = 1'b1;
    bus_if.cmd_opcode = op;
    bus_if.cmd_pchop  = pc;
    bus_if.cmd_rounds = r;
  endtask

  task automatic wait_accept();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_if.cmd_ready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus_if.done) begin ok = 1'b1; break; end
    end
    chk("done_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus_if.cmd_ready), 64'd1);
    chk({tag, "_uc_valid"}, 64'(bus_if.uc_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus_if.done), 64'd0);
    chk({tag, "_opcode"}, 64'(bus_if.opcode_running), 64'd0);
    chk({tag, "_uc_counter"}, 64'(bus_if.uc_counter), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_opcode = '0; bus_if.cmd_pchop = '0;
    bus_if.cmd_rounds = '0; bus_if.abort = 1'b0; bus_if.ucc_ready = 1'b1;
    #12;
    chk_idle("reset");
    chk("reset_pchop", 64'(bus_if.pchop_list), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic walk, one round
    push_walk(4'd5, 32'h1234_5678, 16); done_q.push_back(4'd5);
    snap = n_valid;
    drive_cmd(4'd5, 32'h1234_5678, 4'd1);
    wait_accept();
    chk("basic_first_valid", 64'(bus_if.uc_valid), 64'd1);
    wait_done();
    chk("basic_valid_cycles", 64'(n_valid - snap), 64'd16);
    chk_idle("basic_after");
    chk("basic_pchop_held", 64'(bus_if.pchop_list), 64'h1234_5678);

    // Three rounds
    push_walk(4'hA, 32'hCAFE_0001, 48); done_q.push_back(4'hA);
    snap = n_valid;
    drive_cmd(4'hA, 32'hCAFE_0001, 4'd3);
    wait_accept();
    wait_done();
    chk("rounds3_valid_cycles", 64'(n_valid - snap), 64'd48);

    // Zero rounds behaves as one
    push_walk(4'h2, 32'h0F0F_F0F0, 16); done_q.push_back(4'h2);
    snap = n_valid;
    drive_cmd(4'h2, 32'h0F0F_F0F0, 4'd0);
    wait_accept();
    wait_done();
    chk("rounds0_valid_cycles", 64'(n_valid - snap), 64'd16);

    // Stall for 5 cycles at step 7
    push_walk(4'h6, 32'hA5A5_5A5A, 16); done_q.push_back(4'h6);
    snap = n_valid;
    drive_cmd(4'h6, 32'hA5A5_5A5A, 4'd1);
    wait_accept();
    repeat (7) begin @(posedge clk); #1; end
    bus_if.ucc_ready = 1'b0;
    repeat (5) begin @(negedge clk); chk("stall_hold_ucc2", 64'(bus_if.uc_counter[2*UBW +: UBW]), 64'd39); end
    @(posedge clk); #1;
    bus_if.ucc_ready = 1'b1;
    @(negedge clk); chk("stall_hold_ucc2", 64'(bus_if.uc_counter[2*UBW +: UBW]), 64'd39);
    wait_done();
    chk("stall_run_cycles", 64'(n_valid - snap), 64'd21);

    // Abort at step 10 together with ucc_ready
    push_walk(4'h7, 32'h1111_2222, 11);
    snap = n_valid;
    drive_cmd(4'h7, 32'h1111_2222, 4'd2);
    wait_accept();
    repeat (10) begin @(posedge clk); #1; end
    bus_if.abort = 1'b1;
    @(posedge clk); #1;
    bus_if.abort = 1'b0;
    chk_idle("abort_after");
    repeat (3) @(posedge clk); #1;
    chk("abort_valid_cycles", 64'(n_valid - snap), 64'd11);

    // Command held while busy
    push_walk(4'h3, 32'h3333_3333, 16); done_q.push_back(4'h3);
    push_walk(4'h9, 32'h9999_0000, 16); done_q.push_back(4'h9);
    drive_cmd(4'h3, 32'h3333_3333, 4'd1);
    wait_accept();
    drive_cmd(4'h9, 32'h9999_0000, 4'd1);
    repeat (3) begin
      @(negedge clk);
      chk("busy_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
      chk("busy_pchop_kept", 64'(bus_if.pchop_list), 64'h3333_3333);
    end
    wait_done();
    chk("busy_ready_rises", 64'(bus_if.cmd_ready), 64'd1);
    chk("busy_pchop_until_accept", 64'(bus_if.pchop_list), 64'h3333_3333);
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    chk("second_op_valid", 64'(bus_if.uc_valid), 64'd1);
    chk("second_op_opcode", 64'(bus_if.opcode_running), 64'h9);
    chk("second_op_pchop", 64'(bus_if.pchop_list), 64'h9999_0000);
    wait_done();

    // Asynchronous reset mid-run
    push_walk(4'h4, 32'h4444_0004, 5);
    drive_cmd(4'h4, 32'h4444_0004, 4'd1);
    wait_accept();
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_pchop", 64'(bus_if.pchop_list), 64'd0);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk_idle("post_reset");

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_queue_drained", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
